// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset values,
// the queue entry layout and a word-alignment helper.
package inst_fetch_unit_pkg;

  localparam int          DATA_SIZE      = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_RESET     = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_SIZE-1:0] pc;
    logic [DATA_SIZE-1:0] inst;
  } fetch_entry_t;

  function automatic logic [DATA_SIZE-1:0] align_word(input logic [DATA_SIZE-1:0] addr);
    return {addr[DATA_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_queue.sv
// Synchronous FIFO of {pc, inst} entries with push, pop, flush and count.
// Used both as the prefetch queue and as the per-request PC tracker.
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Flush wins over a same-cycle push so a discarded response never lands.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, prefetch queue
// and redirect flush. Optional FETCH_MISALIGN_CHECK_EN adds misalignFault.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = FETCH_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imemReqValid,
  output logic [DATA_SIZE-1:0] imemReqAddr,
  input  logic                 imemReqReady,
  input  logic                 imemRespValid,
  input  logic [DATA_SIZE-1:0] imemRespData,
  output logic                 instValid,
  output logic [DATA_SIZE-1:0] inst,
  output logic [DATA_SIZE-1:0] instPC,
  input  logic                 instReady,
  input  logic                 redirectValid,
  input  logic [DATA_SIZE-1:0] redirectPC
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                 misalignFault
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int SW = CW + 1;

  logic [DATA_SIZE-1:0] pc_q, pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [CW-1:0]        data_count, credit_count;
  fetch_entry_t         data_head, credit_head, data_in, credit_in;
  logic                 halted, req_fire, resp_live, resp_keep, pop;
  logic                 unused_credit_inst;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign halted        = fault_q;
  assign misalignFault = fault_q;
`else
  assign halted = 1'b0;
`endif

  // Credits cover both in-flight requests and queued instructions, so the
  // queue can never overflow however long decode stalls.
  assign imemReqValid = !rst && !halted &&
                        ((SW'(outstanding_q) + SW'(data_count)) < SW'(QUEUE_DEPTH));
  assign imemReqAddr  = pc_q;
  assign req_fire     = imemReqValid && imemReqReady;
  assign resp_live    = imemRespValid && (outstanding_q != '0);
  assign resp_keep    = resp_live && (drop_q == '0) && (credit_count != '0);
  assign instValid    = (data_count != '0) && !redirectValid;
  assign pop          = instValid && instReady;
  assign inst         = data_head.inst;
  assign instPC       = data_head.pc;

  assign credit_in          = '{pc: pc_q, inst: INST_RESET};
  assign data_in            = '{pc: credit_head.pc, inst: imemRespData};
  assign unused_credit_inst = ^credit_head.inst;

  // A redirect discards everything still in flight, including a request
  // accepted in the redirect cycle itself.
  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_live);
    drop_d        = drop_q;
    pc_d          = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d       = fault_q;
`endif
    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
    if (resp_live && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (redirectValid) begin
      drop_d = outstanding_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirectPC[1:0] != 2'b00) begin
        fault_d = 1'b1;
        pc_d    = pc_q;
      end else begin
        pc_d = redirectPC;
      end
`else
      pc_d = align_word(redirectPC);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q       <= fault_d;
`endif
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .CW(CW)) u_data_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data (data_in),
    .pop       (pop),
    .flush     (redirectValid),
    .count     (data_count),
    .head      (data_head)
  );

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .CW(CW)) u_credit_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (credit_in),
    .pop       (resp_keep),
    .flush     (redirectValid),
    .count     (credit_count),
    .head      (credit_head)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table plus randomized traffic
// against a queue-based reference model and an in-order memory model.
module tb_inst_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst;
  logic        imemReqValid, imemReqReady, imemRespValid;
  logic [31:0] imemReqAddr, imemRespData;
  logic        instValid, instReady, redirectValid;
  logic [31:0] inst, instPC, redirectPC;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalignFault;
`endif

  inst_fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imemReqValid  (imemReqValid),
    .imemReqAddr   (imemReqAddr),
    .imemReqReady  (imemReqReady),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .instValid     (instValid),
    .inst          (inst),
    .instPC        (instPC),
    .instReady     (instReady),
    .redirectValid (redirectValid),
    .redirectPC    (redirectPC)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalignFault (misalignFault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    bit          mem_ready;
    bit          inst_ready;
    bit          redirect;
    logic [31:0] redirect_pc;
    bit          exp_req_valid;
    logic [31:0] exp_req_addr;
    bit          exp_inst_valid;
    logic [31:0] exp_inst_pc;
  } vec_t;

  typedef struct { logic [31:0] pc; bit dropped; } issued_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } slot_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  issued_t     issued[$];
  slot_t       slots[$];
  pend_t       pend[$];
  vec_t        vecs[$];
  logic [31:0] m_pc;
  bit          m_fault;
  int          cycle, last_due, lat;
  int          ready_pct, inst_pct, redir_pct;
  int          live_out, max_out;
  int          tests, fails;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic vec_t mk(input bit rb, input bit mr, input bit ir, input bit rd,
                              input logic [31:0] rp, input bit ev, input logic [31:0] ea,
                              input bit iv, input logic [31:0] ip);
    vec_t v;
    v = '{rb, mr, ir, rd, rp, ev, ea, iv, ip};
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    imemReqReady  = 1'b0;
    imemRespValid = 1'b0;
    imemRespData  = '0;
    instReady     = 1'b0;
    redirectValid = 1'b0;
    redirectPC    = '0;
    pend.delete();
    issued.delete();
    slots.delete();
    live_out = 0;
    #2;
    check_output("rst_reqValid", 32'(imemReqValid), 32'd0);
    check_output("rst_reqAddr", imemReqAddr, RST_PC);
    check_output("rst_instValid", 32'(instValid), 32'd0);
    check_output("rst_inst", inst, 32'd0);
    check_output("rst_instPC", instPC, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_output("rst_misalign", 32'(misalignFault), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_pc     = RST_PC;
    m_fault  = 1'b0;
    cycle    = 1;
    last_due = 0;
  endtask

  task automatic apply_stimulus(input bit directed, input vec_t v);
    logic [31:0] rp;
    if (directed) begin
      imemReqReady  = v.mem_ready;
      instReady     = v.inst_ready;
      redirectValid = v.redirect;
      redirectPC    = v.redirect_pc;
    end else begin
      imemReqReady  = ($urandom_range(99) < ready_pct);
      instReady     = ($urandom_range(99) < inst_pct);
      redirectValid = ($urandom_range(99) < redir_pct);
      rp            = $urandom;
      rp[31:12]     = '0;
      if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
      redirectPC    = rp;
    end
    if (pend.size() > 0 && pend[0].due <= cycle) begin
      imemRespValid = 1'b1;
      imemRespData  = mem_word(pend[0].addr);
      void'(pend.pop_front());
      live_out--;
    end else if (!directed && pend.size() == 0 && issued.size() == 0 &&
                 $urandom_range(7) == 0) begin
      imemRespValid = 1'b1;
      imemRespData  = $urandom;
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = $urandom;
    end
  endtask

  task automatic step(input bit directed, input vec_t v);
    bit          exp_req_valid, exp_inst_valid, m_fire, m_pop, dut_fire;
    logic [31:0] dut_addr, pc_before;
    issued_t     e;
    int          due;
    apply_stimulus(directed, v);
    #2;
    exp_req_valid  = !m_fault && (issued.size() + slots.size() < DEPTH);
    exp_inst_valid = (slots.size() != 0) && !redirectValid;
    check_output("reqValid", 32'(imemReqValid), 32'(exp_req_valid));
    check_output("reqAddr", imemReqAddr, m_pc);
    check_output("instValid", 32'(instValid), 32'(exp_inst_valid));
    if (exp_inst_valid) begin
      check_output("instPC", instPC, slots[0].pc);
      check_output("inst", inst, slots[0].inst);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    check_output("misalignFault", 32'(misalignFault), 32'(m_fault));
`endif
    if (directed) begin
      check_output("tbl_reqValid", 32'(imemReqValid), 32'(v.exp_req_valid));
      check_output("tbl_reqAddr", imemReqAddr, v.exp_req_addr);
      check_output("tbl_instValid", 32'(instValid), 32'(v.exp_inst_valid));
      if (v.exp_inst_valid) check_output("tbl_instPC", instPC, v.exp_inst_pc);
    end
    dut_fire = imemReqValid && imemReqReady;
    dut_addr = imemReqAddr;
    m_fire   = exp_req_valid && imemReqReady;
    m_pop    = exp_inst_valid && instReady;
    @(posedge clk);
    if (dut_fire) begin
      due = cycle + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{dut_addr, due});
      live_out++;
      if (live_out > max_out) max_out = live_out;
    end
    if (m_pop) void'(slots.pop_front());
    if (imemRespValid && issued.size() > 0) begin
      e = issued.pop_front();
      if (!e.dropped) slots.push_back('{e.pc, imemRespData});
    end
    pc_before = m_pc;
    if (m_fire) begin
      issued.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redirectValid) begin
      foreach (issued[i]) issued[i].dropped = 1'b1;
      slots.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirectPC[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_pc    = pc_before;
      end else begin
        m_pc = redirectPC;
      end
`else
      m_pc = {redirectPC[31:2], 2'b00};
`endif
    end
    cycle++;
    #1;
  endtask

  task automatic run_random(input int n);
    vec_t dummy;
    dummy = mk(0, 0, 0, 0, '0, 0, '0, 0, '0);
    for (int i = 0; i < n; i++) step(1'b0, dummy);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    max_out = 0;
    lat     = 1;

    // Reset release with 1-cycle memory, then a redirect while an entry is queued.
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h000, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h004, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       0, 32'h008, 1, 32'h000));
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h008, 1, 32'h004));
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h00C, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       0, 32'h010, 1, 32'h008));
    vecs.push_back(mk(0, 1, 1, 1, 32'h100,  1, 32'h010, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h100, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h104, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       0, 32'h108, 1, 32'h100));
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h108, 1, 32'h104));
    // Misaligned redirect right after reset.
    vecs.push_back(mk(1, 0, 1, 1, 32'h102,  1, 32'h000, 0, '0));
`ifdef FETCH_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 1, 1, 0, '0,       0, 32'h000, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       0, 32'h000, 0, '0));
`else
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h100, 0, '0));
    vecs.push_back(mk(0, 1, 1, 0, '0,       1, 32'h104, 0, '0));
`endif

    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      step(1'b1, vecs[i]);
    end

    do_reset();
    lat = 1; ready_pct = 100; inst_pct = 70; redir_pct = 5;
    run_random(300);

    inst_pct = 0;
    run_random(8);
    inst_pct = 100;
    run_random(20);

    lat = 3; ready_pct = 50; inst_pct = 60; redir_pct = 3;
    run_random(300);

    do_reset();
    lat = 2; ready_pct = 80; inst_pct = 50; redir_pct = 20;
    run_random(300);

    tests++;
    if (max_out > DEPTH) begin
      fails++;
      $display("[TB] FAIL maxOutstanding: got %0d expected at most %0d", max_out, DEPTH);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
